// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and line-level constants (TX and RX sides).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_parity_calc.sv
// ============================================================================
// Module      : uart_tx_parity_calc
// Description : Combinational parity of DATA_WIDTH bits; i_par_typ selects
//               even (PAR_EVEN) or odd (PAR_ODD) parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_par_typ,
    output logic                  o_parity
);

    // Even parity makes the total count of ones even; odd flips it.
    assign o_parity = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule : uart_tx_parity_calc

`default_nettype wire

// File: rtl/uart_tx_core.sv
// ============================================================================
// Module      : uart_tx_core
// Description : UART transmitter, one serial bit per CLK: start, data LSB
//               first, optional parity, stop. Optional one-word hold register
//               enabled by defining UART_TX_HOLD_REG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  parity_q, parity_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;

    logic                  w_accept;
    logic                  w_src_valid;
    logic [DATA_WIDTH-1:0] w_src_data;
    logic                  w_src_par_en;
    logic                  w_src_par_typ;
    logic                  w_src_parity;
    logic                  w_load_frame;

    assign w_accept = Data_Valid && !busy_q;

`ifdef UART_TX_HOLD_REG_EN
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_par_en_q, hold_par_en_d;
    logic                  hold_par_typ_q, hold_par_typ_d;

    // A waiting word always goes out before a freshly presented one.
    always_comb begin
        w_src_valid   = hold_valid_q || w_accept;
        w_src_data    = hold_valid_q ? hold_data_q    : P_DATA;
        w_src_par_en  = hold_valid_q ? hold_par_en_q  : PAR_EN;
        w_src_par_typ = hold_valid_q ? hold_par_typ_q : PAR_TYP;
    end

    always_comb begin
        hold_valid_d   = hold_valid_q;
        hold_data_d    = hold_data_q;
        hold_par_en_d  = hold_par_en_q;
        hold_par_typ_d = hold_par_typ_q;
        if (w_load_frame && hold_valid_q) begin
            hold_valid_d = 1'b0;
        end
        // An accepted word parks in the hold register unless it went
        // straight into the frame registers this edge.
        if (w_accept && !(w_load_frame && !hold_valid_q)) begin
            hold_valid_d   = 1'b1;
            hold_data_d    = P_DATA;
            hold_par_en_d  = PAR_EN;
            hold_par_typ_d = PAR_TYP;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_valid_q   <= 1'b0;
            hold_data_q    <= '0;
            hold_par_en_q  <= 1'b0;
            hold_par_typ_q <= 1'b0;
        end else begin
            hold_valid_q   <= hold_valid_d;
            hold_data_q    <= hold_data_d;
            hold_par_en_q  <= hold_par_en_d;
            hold_par_typ_q <= hold_par_typ_d;
        end
    end

    assign busy_d = hold_valid_d;
`else
    always_comb begin
        w_src_valid   = w_accept;
        w_src_data    = P_DATA;
        w_src_par_en  = PAR_EN;
        w_src_par_typ = PAR_TYP;
    end

    assign busy_d = (state_d != IDLE);
`endif

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .i_data    (w_src_data),
        .i_par_typ (w_src_par_typ),
        .o_parity  (w_src_parity)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        par_en_d     = par_en_q;
        parity_d     = parity_q;
        w_load_frame = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_src_valid) begin
                    w_load_frame = 1'b1;
                    state_d      = START;
                end
            end
            START: begin
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = par_en_q ? PARITY : STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
                if (w_src_valid) begin
                    w_load_frame = 1'b1;
                    state_d      = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase

        if (w_load_frame) begin
            data_d    = w_src_data;
            par_en_d  = w_src_par_en;
            parity_d  = w_src_parity;
            bit_cnt_d = '0;
        end
    end

    // The line level is registered against the state being entered, so the
    // start bit appears on the same edge that accepts the word.
    always_comb begin
        tx_out_d = LINE_IDLE;
        case (state_d)
            IDLE:    tx_out_d = LINE_IDLE;
            START:   tx_out_d = LINE_START;
            DATA:    tx_out_d = data_d[bit_cnt_d];
            PARITY:  tx_out_d = parity_d;
            STOP:    tx_out_d = LINE_STOP;
            default: tx_out_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            parity_q  <= 1'b0;
            tx_out_q  <= LINE_IDLE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            parity_q  <= parity_d;
            tx_out_q  <= tx_out_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT = tx_out_q;
    assign busy   = busy_q;

endmodule : uart_tx_core

`default_nettype wire

// File: tb/tb_uart_tx_core.sv
// ============================================================================
// Module      : tb_uart_tx_core
// Description : Self-checking bench for uart_tx_core (8-bit words); frame
//               expectations come from a bit-level frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_core;

    localparam int W = 8;
`ifdef UART_TX_HOLD_REG_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [W-1:0] P_DATA = '0;
    logic         Data_Valid = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         TX_OUT;
    logic         busy;

    int errors = 0;
    int checks = 0;

    uart_tx_core #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Frame model: bit k of the serial frame for a given word and settings.
    function automatic int frame_len(input logic pen);
        return W + 2 + (pen ? 1 : 0);
    endfunction

    function automatic logic exp_bit(input logic [W-1:0] d, input logic pen,
                                     input logic ptyp, input int k);
        if (k == 0) return 1'b0;
        if (k <= W) return d[k-1];
        if (pen && k == W + 1) return logic'($countones(d) % 2) ^ ptyp;
        return 1'b1;
    endfunction

    // Present a word at the next negedge; returns after the accepting edge.
    task automatic present(input logic [W-1:0] d, input logic pen, input logic ptyp);
        @(negedge CLK);
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", TX_OUT, busy);
        end
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", TX_OUT, busy);
        end
    endtask

    // Send one word, scramble the inputs right after acceptance, check the frame.
    task automatic test_frame(input string name, input logic [W-1:0] d,
                              input logic pen, input logic ptyp, input logic [W-1:0] scramble);
        int len;
        len = frame_len(pen);
        present(d, pen, ptyp);
        P_DATA  = scramble;
        PAR_EN  = ~pen;
        PAR_TYP = ~ptyp;
        for (int k = 0; k < len; k++) begin
            checks++;
            if (TX_OUT !== exp_bit(d, pen, ptyp, k) || busy !== !HOLD_EN) begin
                errors++;
                $display("FAIL %s bit%0d: TX_OUT=%b busy=%b, want TX_OUT=%b busy=%b",
                         name, k, TX_OUT, busy, exp_bit(d, pen, ptyp, k), !HOLD_EN);
            end
            @(negedge CLK);
        end
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_stop: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", name, TX_OUT, busy);
        end
    endtask

    task automatic test_random_frames();
        logic [W-1:0] d;
        logic         pen, ptyp;
        for (int n = 0; n < 6; n++) begin
            d    = W'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            test_frame($sformatf("random%0d", n), d, pen, ptyp, ~d);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_q[$];
        int   gap;
        int   nbits;
        gap = HOLD_EN ? 0 : 1;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < frame_len(1'b0); k++) exp_q.push_back(exp_bit(8'h3C, 1'b0, 1'b0, k));
            if (f == 0) for (int g = 0; g < gap; g++) exp_q.push_back(1'b1);
        end
        nbits = exp_q.size();
        @(negedge CLK);
        P_DATA     = 8'h3C;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
        @(negedge CLK);
        for (int k = 0; k < nbits; k++) begin
            checks++;
            if (TX_OUT !== exp_q[k]) begin
                errors++;
                $display("FAIL back_to_back bit%0d: TX_OUT=%b, want %b", k, TX_OUT, exp_q[k]);
            end
            if (!HOLD_EN && k == frame_len(1'b0)) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL back_to_back gap_busy: busy=%b, want 0", busy);
                end
            end
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        repeat (40) @(negedge CLK);
    endtask

    task automatic test_reset_mid_frame();
        present(8'hFF, 1'b0, 1'b0);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame async: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", TX_OUT, busy);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_frame no_resume c%0d: TX_OUT=%b busy=%b, want 1/0", k, TX_OUT, busy);
            end
        end
        test_frame("after_reset_55", 8'h55, 1'b0, 1'b0, 8'h00);
    endtask

    // A second request during a frame is dropped without a hold register
    // and queued behind the first frame with one.
    task automatic test_busy_ignore();
        logic exp_q[$];
        int   len1;
        len1 = frame_len(1'b1);
        for (int k = 0; k < len1; k++) exp_q.push_back(exp_bit(8'h81, 1'b1, 1'b0, k));
        if (HOLD_EN)
            for (int k = 0; k < frame_len(1'b0); k++) exp_q.push_back(exp_bit(8'h7E, 1'b0, 1'b0, k));
        for (int k = 0; k < 6; k++) exp_q.push_back(1'b1);
        present(8'h81, 1'b1, 1'b0);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (TX_OUT !== exp_q[k]) begin
                errors++;
                $display("FAIL busy_ignore bit%0d: TX_OUT=%b, want %b", k, TX_OUT, exp_q[k]);
            end
            if (!HOLD_EN) begin
                checks++;
                if (busy !== (k < len1)) begin
                    errors++;
                    $display("FAIL busy_ignore busy%0d: busy=%b, want %b", k, busy, (k < len1));
                end
            end
            if (k == 3) begin
                P_DATA     = 8'h7E;
                PAR_EN     = 1'b0;
                PAR_TYP    = 1'b0;
                Data_Valid = 1'b1;
            end else begin
                Data_Valid = 1'b0;
            end
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame("a5_nopar",   8'hA5, 1'b0, 1'b0, 8'h5A);
        test_frame("a5_even",    8'hA5, 1'b1, 1'b0, 8'h00);
        test_frame("a5_odd",     8'hA5, 1'b1, 1'b1, 8'hFF);
        test_frame("01_odd_chg", 8'h01, 1'b1, 1'b1, 8'hFF);
        test_random_frames();
        test_back_to_back();
        test_reset_mid_frame();
        test_busy_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_uart_tx_core

`default_nettype wire
